// File: rtl/grid_pkg.sv
// Shared constants and types for the life-grid pixel datapath and its control side.
package grid_pkg;

    localparam int GRID_COLS    = 40;
    localparam int GRID_ROWS    = 30;
    localparam int CELL_PX_LOG2 = 2;
    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;

    localparam logic [2:0] COLOUR_LIVE = 3'b111;
    localparam logic [2:0] COLOUR_DEAD = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRAW
    } state_e;

endpackage

// File: rtl/cell_offset_counter.sv
// 4-bit pixel offset within a cell: clear restarts the cell, enable advances it, wraps 15 -> 0.
module cell_offset_counter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] off_o,
    output logic       last_o
);

    logic [3:0] off_q, off_d;

    // Clear and enable in the same cycle count the restarted cell's first pixel.
    always_comb begin
        off_d = clr_i ? 4'd0 : off_q;
        if (en_i) off_d = off_d + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) off_q <= 4'd0;
        else         off_q <= off_d;
    end

    assign off_o  = off_q;
    assign last_o = (off_q == 4'hF);

endmodule

// File: rtl/cell_pixel_datapath.sv
// Expands one latched grid cell into 16 registered VGA pixel writes with cell/frame strobes.
module cell_pixel_datapath
    import grid_pkg::*;
#(
    parameter logic [2:0] LIVE_COLOUR = COLOUR_LIVE,
    parameter logic [2:0] DEAD_COLOUR = COLOUR_DEAD,
    parameter int         COLS        = GRID_COLS,
    parameter int         ROWS        = GRID_ROWS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_x,
    input  logic            ld_y,
    input  logic            ld_c,
    input  logic            plot,
    input  logic [4:0]      register,
    input  logic [5:0]      addr,
    input  logic [COLS-1:0] data,
    output logic [7:0]      x,
    output logic [6:0]      y,
    output logic [2:0]      colour,
    output logic            writeEn,
    output logic            cell_done,
    output logic            frame_done,
    output logic            range_err
);

    logic [5:0] col_q, col_d, bit_idx;
    logic [4:0] row_q, row_d;
    logic       live_q, live_d;
    state_e     state_q, state_d;
    logic [3:0] off_q, off_eff;
    logic       off_last, relatch, in_range, emit_last, emit;

    cell_offset_counter u_off (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (relatch),
        .en_i    (plot),
        .off_o   (off_q),
        .last_o  (off_last)
    );

    // A pixel plotted in the same cycle as a relatch uses the new coordinate at offset 0.
    always_comb begin
        relatch   = ld_x | ld_y;
        col_d     = ld_x ? addr : col_q;
        row_d     = ld_y ? register : row_q;
        bit_idx   = 6'(COLS - 1) - col_d;
        live_d    = live_q;
        if (ld_c) live_d = (col_d < 6'(COLS)) ? data[bit_idx] : 1'b0;
        in_range  = (row_d < 5'(ROWS)) && (col_d < 6'(COLS));
        off_eff   = relatch ? 4'd0 : off_q;
        emit_last = off_last & ~relatch;
        emit      = plot & in_range;
    end

    always_comb begin
        state_d = state_q;
        if (relatch) begin
            state_d = plot ? DRAW : ARMED;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ARMED:   if (plot) state_d = DRAW;
                DRAW:    if (!plot || emit_last) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= 6'd0;
            row_q      <= 5'd0;
            live_q     <= 1'b0;
            state_q    <= IDLE;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= DEAD_COLOUR;
            writeEn    <= 1'b0;
            cell_done  <= 1'b0;
            frame_done <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            live_q     <= live_d;
            state_q    <= state_d;
            writeEn    <= emit;
            cell_done  <= emit & emit_last;
            frame_done <= emit & emit_last &
                          (row_d == 5'(ROWS - 1)) & (col_d == 6'(COLS - 1));
            if (emit) begin
                x      <= {col_d, off_eff[1:0]};
                y      <= {row_d, off_eff[3:2]};
                colour <= live_d ? LIVE_COLOUR : DEAD_COLOUR;
            end
            if (plot && !in_range) range_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cell_pixel_datapath.sv
// Directed bench for cell_pixel_datapath with hand-computed pixel expectations.
module tb_cell_pixel_datapath;

    logic        clk = 1'b0;
    logic        reset, ld_x, ld_y, ld_c, plot;
    logic [4:0]  register;
    logic [5:0]  addr;
    logic [39:0] data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn, cell_done, frame_done, range_err;

    int   checks = 0;
    int   errors = 0;
    logic exp_rerr = 1'b0;

    cell_pixel_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_c       (ld_c),
        .plot       (plot),
        .register   (register),
        .addr       (addr),
        .data       (data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .cell_done  (cell_done),
        .frame_done (frame_done),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic latch(input int r, input int c, input logic [39:0] d);
        register = 5'(r);
        addr     = 6'(c);
        data     = d;
        ld_x = 1'b1; ld_y = 1'b1; ld_c = 1'b1; plot = 1'b0;
        step();
        ld_x = 1'b0; ld_y = 1'b0; ld_c = 1'b0;
        chk("latch_wr_idle", 16'(writeEn), 16'd0);
    endtask

    task automatic pix(input int r, input int c, input int k, input logic [2:0] ce);
        logic [7:0] ex;
        logic [6:0] ey;
        logic       last;
        ex   = 8'(c * 4 + k % 4);
        ey   = 7'(r * 4 + k / 4);
        last = (k == 15);
        plot = 1'b1;
        step();
        chk("wr_en", 16'(writeEn), 16'd1);
        chk("x", 16'(x), 16'(ex));
        chk("y", 16'(y), 16'(ey));
        chk("colour", 16'(colour), 16'(ce));
        chk("cell_done", 16'(cell_done), 16'(last));
        chk("frame_done", 16'(frame_done), 16'(last && r == 29 && c == 39));
        chk("range_err", 16'(range_err), 16'(exp_rerr));
    endtask

    initial begin
        reset = 1'b1; ld_x = 1'b0; ld_y = 1'b0; ld_c = 1'b0; plot = 1'b0;
        register = 5'd0; addr = 6'd0; data = 40'd0;
        step();
        step();
        reset = 1'b0;
        chk("rst_wr", 16'(writeEn), 16'd0);
        chk("rst_x", 16'(x), 16'd0);
        chk("rst_y", 16'(y), 16'd0);
        chk("rst_colour", 16'(colour), 16'd0);
        chk("rst_cell_done", 16'(cell_done), 16'd0);
        chk("rst_frame_done", 16'(frame_done), 16'd0);
        chk("rst_range_err", 16'(range_err), 16'd0);

        // Reset mid-draw at off=7, then one plot must land on (0,0) offset 0.
        latch(1, 1, 40'h1 << 38);
        for (int k = 0; k < 7; k++) pix(1, 1, k, 3'b111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_wr", 16'(writeEn), 16'd0);
        chk("midrst_x", 16'(x), 16'd0);
        chk("midrst_y", 16'(y), 16'd0);
        chk("midrst_colour", 16'(colour), 16'd0);
        chk("midrst_range_err", 16'(range_err), 16'd0);
        pix(0, 0, 0, 3'b000);
        plot = 1'b0;
        step();

        // Single live cell (2,3): x 12..15, y 8..11.
        latch(2, 3, 40'h1 << 36);
        for (int k = 0; k < 16; k++) pix(2, 3, k, 3'b111);
        plot = 1'b0;
        step();
        chk("single_idle_wr", 16'(writeEn), 16'd0);
        chk("single_idle_cd", 16'(cell_done), 16'd0);
        chk("single_hold_x", 16'(x), 16'd15);

        // Dead cell with ld_c held; bit flips before the 6th plot.
        latch(2, 3, 40'h0);
        ld_c = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 5) data = 40'h1 << 36;
            pix(2, 3, k, (k >= 5) ? 3'b111 : 3'b000);
        end
        ld_c = 1'b0;
        plot = 1'b0;
        step();

        // Last cell of the frame.
        latch(29, 39, 40'h1);
        for (int k = 0; k < 16; k++) pix(29, 39, k, 3'b111);
        chk("last_x", 16'(x), 16'd159);
        chk("last_y", 16'(y), 16'd119);
        plot = 1'b0;
        step();
        chk("last_fd_pulse", 16'(frame_done), 16'd0);

        // Pause after 5 pixels, resume, then relatch column mid-draw.
        latch(5, 10, 40'h1 << 29);
        for (int k = 0; k < 5; k++) pix(5, 10, k, 3'b111);
        plot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_wr", 16'(writeEn), 16'd0);
            chk("pause_hold_x", 16'(x), 16'd40);
            chk("pause_hold_y", 16'(y), 16'd21);
        end
        for (int k = 5; k < 10; k++) pix(5, 10, k, 3'b111);
        plot = 1'b0;
        addr = 6'd12;
        ld_x = 1'b1;
        step();
        ld_x = 1'b0;
        for (int k = 0; k < 16; k++) pix(5, 12, k, 3'b111);
        plot = 1'b0;

        // Out-of-range row: no writes, sticky error, cadence preserved.
        latch(30, 0, 40'h1 << 39);
        for (int i = 0; i < 16; i++) begin
            plot = 1'b1;
            step();
            chk("oor_wr", 16'(writeEn), 16'd0);
            chk("oor_cell_done", 16'(cell_done), 16'd0);
            chk("oor_range_err", 16'(range_err), 16'd1);
        end
        plot = 1'b0;
        step();
        chk("oor_hold_x", 16'(x), 16'd51);
        chk("oor_hold_y", 16'(y), 16'd23);
        exp_rerr = 1'b1;
        latch(4, 7, 40'h1 << 32);
        for (int k = 0; k < 16; k++) pix(4, 7, k, 3'b111);
        plot = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
